// File: rtl/count_chk_pkg.sv
// Shared types and default parameters for the count sequence checker.
package count_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } chk_state_t;

  localparam int unsigned DEF_WIDTH       = 4;
  localparam int unsigned DEF_LOCK_CYCLES = 2;
  localparam int unsigned DEF_STAT_W      = 8;

endpackage

// File: rtl/count_seq_checker_if.sv
// Monitor-side bundle: sampled counter stream in, lock/error/wrap status out.
interface count_seq_checker_if
  import count_chk_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAT_W = DEF_STAT_W
);

  logic              en;
  logic [WIDTH-1:0]  count_in;
  logic              clear;
  logic              locked;
  logic [WIDTH-1:0]  expected;
  logic              err_pulse;
  logic [STAT_W-1:0] err_count;
  logic              wrap_pulse;
  logic [STAT_W-1:0] wrap_count;

  modport master (
    output en, count_in, clear,
    input  locked, expected, err_pulse, err_count, wrap_pulse, wrap_count
  );

  modport slave (
    input  en, count_in, clear,
    output locked, expected, err_pulse, err_count, wrap_pulse, wrap_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter; a same-cycle clear beats an increment.
module sat_counter #(
  parameter int unsigned STAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [STAT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {STAT_W{1'b1}})) begin
      q <= q + STAT_W'(1);
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// In-system checker for an up-counter stream: acquires lock on consecutive
// +1 steps, then flags mismatches and max->0 rollovers with statistics.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int unsigned STAT_W      = DEF_STAT_W
) (
  input logic                clk,
  input logic                rst,
  count_seq_checker_if.slave bus
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CYCLES + 1);

  chk_state_t        state, state_n;
  logic [GOOD_W-1:0] good, good_n;
  logic [WIDTH-1:0]  expected_q, expected_n;
  logic              locked_q, locked_n;
  logic              err_q, err_n;
  logic              wrap_q, wrap_n;
  logic              match_c;
  logic [WIDTH-1:0]  count_inc_c;
  logic [GOOD_W-1:0] good_inc_c;
  logic [STAT_W-1:0] err_cnt;
  logic [STAT_W-1:0] wrap_cnt;

  assign match_c     = (bus.count_in == expected_q);
  assign count_inc_c = WIDTH'(bus.count_in + WIDTH'(1));
  assign good_inc_c  = good + GOOD_W'(1);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      good       <= '0;
      expected_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state      <= state_n;
      good       <= good_n;
      expected_q <= expected_n;
      locked_q   <= locked_n;
      err_q      <= err_n;
      wrap_q     <= wrap_n;
    end
  end

  // Next-state; every qualified sample re-arms expected from the observed value
  always_comb begin
    state_n    = state;
    good_n     = good;
    expected_n = expected_q;
    locked_n   = locked_q;
    err_n      = 1'b0;
    wrap_n     = 1'b0;
    if (bus.en) begin
      expected_n = count_inc_c;
      unique case (state)
        IDLE: begin
          good_n  = '0;
          state_n = ACQUIRE;
        end
        ACQUIRE: begin
          if (match_c) begin
            good_n = good_inc_c;
            if (good_inc_c == GOOD_W'(LOCK_CYCLES)) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
            end
          end else begin
            good_n = '0;
          end
        end
        LOCKED: begin
          if (match_c) begin
            wrap_n = (bus.count_in == '0);
          end else begin
            err_n    = 1'b1;
            locked_n = 1'b0;
            good_n   = '0;
            state_n  = ACQUIRE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  sat_counter #(.STAT_W(STAT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.clear),
    .inc (err_n),
    .q   (err_cnt)
  );

  sat_counter #(.STAT_W(STAT_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.clear),
    .inc (wrap_n),
    .q   (wrap_cnt)
  );

  assign bus.locked     = locked_q;
  assign bus.expected   = expected_q;
  assign bus.err_pulse  = err_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.err_count  = err_cnt;
  assign bus.wrap_count = wrap_cnt;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed plus randomized bench for count_seq_checker against a sequence-rule model.
module tb_count_seq_checker;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned LOCK   = 2;
  localparam int unsigned STAT_W = 2;
  localparam int          STAT_MAX = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  count_seq_checker_if #(.WIDTH(WIDTH), .STAT_W(STAT_W)) bus ();

  count_seq_checker #(.WIDTH(WIDTH), .LOCK_CYCLES(LOCK), .STAT_W(STAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: "seen" means a first sample since reset was taken; run counts
  // consecutive correct +1 steps while not locked.
  bit         m_seen;
  bit         m_locked;
  int         m_run;
  logic [3:0] m_exp;
  int         m_err, m_wrap;
  bit         m_errp, m_wrapp;

  task automatic model(input logic r, input logic e, input logic [3:0] c, input logic cl);
    if (!r) begin
      m_seen = 0; m_locked = 0; m_run = 0; m_exp = 4'd0;
      m_err = 0; m_wrap = 0; m_errp = 0; m_wrapp = 0;
    end else begin
      m_errp = 0; m_wrapp = 0;
      if (e) begin
        if (!m_seen) begin
          m_seen = 1; m_run = 0;
        end else if (c == m_exp) begin
          if (m_locked) m_wrapp = (c == 4'd0);
          else begin
            m_run++;
            if (m_run >= LOCK) m_locked = 1;
          end
        end else begin
          if (m_locked) m_errp = 1;
          m_locked = 0; m_run = 0;
        end
        m_exp = 4'((int'(c) + 1) % 16);
      end
      if (cl) begin
        m_err = 0; m_wrap = 0;
      end else begin
        if (m_errp && m_err < STAT_MAX) m_err++;
        if (m_wrapp && m_wrap < STAT_MAX) m_wrap++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("locked",     8'(bus.locked),     8'(m_locked));
    chk("expected",   8'(bus.expected),   8'(m_exp));
    chk("err_pulse",  8'(bus.err_pulse),  8'(m_errp));
    chk("wrap_pulse", 8'(bus.wrap_pulse), 8'(m_wrapp));
    chk("err_count",  8'(bus.err_count),  8'(m_err));
    chk("wrap_count", 8'(bus.wrap_count), 8'(m_wrap));
    chk("pulse_excl", 8'(bus.err_pulse & bus.wrap_pulse), 8'd0);
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] c, input logic cl);
    @(negedge clk);
    rst = r; bus.en = e; bus.count_in = c; bus.clear = cl;
    @(posedge clk);
    model(r, e, c, cl);
    #1;
    check_all();
  endtask

  initial begin
    logic [3:0] v;
    rst = 1'b0; bus.en = 1'b0; bus.count_in = '0; bus.clear = 1'b0;

    // 1: reset overrides en
    step(0, 1, 4'd9, 0);
    step(0, 1, 4'd9, 0);
    chk("t1_locked", 8'(bus.locked), 8'd0);
    chk("t1_expected", 8'(bus.expected), 8'd0);

    // 2: lock on the third sample
    step(1, 1, 4'd0, 0);
    step(1, 1, 4'd1, 0);
    chk("t2_not_yet", 8'(bus.locked), 8'd0);
    step(1, 1, 4'd2, 0);
    chk("t2_locked", 8'(bus.locked), 8'd1);
    chk("t2_expected", 8'(bus.expected), 8'd3);

    // 3: rollover while locked
    for (int i = 3; i <= 15; i++) step(1, 1, 4'(i), 0);
    step(1, 1, 4'd0, 0);
    chk("t3_wrap_pulse", 8'(bus.wrap_pulse), 8'd1);
    chk("t3_wrap_count", 8'(bus.wrap_count), 8'd1);
    chk("t3_expected", 8'(bus.expected), 8'd1);
    step(1, 0, 4'd0, 0);
    chk("t3_wrap_once", 8'(bus.wrap_pulse), 8'd0);

    // 4: mid-stream counter reset, then relock
    for (int i = 1; i <= 4; i++) step(1, 1, 4'(i), 0);
    chk("t4_exp5", 8'(bus.expected), 8'd5);
    step(1, 1, 4'd0, 0);
    chk("t4_err_pulse", 8'(bus.err_pulse), 8'd1);
    chk("t4_err_count", 8'(bus.err_count), 8'd1);
    chk("t4_unlocked", 8'(bus.locked), 8'd0);
    step(1, 1, 4'd1, 0);
    chk("t4_err_once", 8'(bus.err_pulse), 8'd0);
    step(1, 1, 4'd2, 0);
    chk("t4_relocked", 8'(bus.locked), 8'd1);

    // 5: stall with garbage on count_in
    for (int i = 3; i <= 7; i++) step(1, 1, 4'(i), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 4'd3, 0);
    step(1, 1, 4'd8, 0);
    chk("t5_locked", 8'(bus.locked), 8'd1);
    chk("t5_expected", 8'(bus.expected), 8'd9);
    chk("t5_err_count", 8'(bus.err_count), 8'd1);

    // 6: saturation, then clear beating an increment
    for (int k = 0; k < 4; k++) begin
      v = 4'(m_exp + 4'd5);
      step(1, 1, v, 0);
      v = v + 4'd1; step(1, 1, v, 0);
      v = v + 4'd1; step(1, 1, v, 0);
    end
    chk("t6_saturated", 8'(bus.err_count), 8'd3);
    chk("t6_relocked", 8'(bus.locked), 8'd1);
    v = 4'(m_exp + 4'd7);
    step(1, 1, v, 1);
    chk("t6_clr_pulse", 8'(bus.err_pulse), 8'd1);
    chk("t6_clr_count", 8'(bus.err_count), 8'd0);

    // Randomized: mostly-correct stream with glitches, stalls, clears, resets
    for (int n = 0; n < 1500; n++) begin
      logic e, cl, r;
      logic [3:0] c;
      r  = ($urandom_range(0, 199) != 0);
      e  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 39) == 0);
      c  = ($urandom_range(0, 99) < 85) ? m_exp : 4'($urandom_range(0, 15));
      step(r, e, c, cl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
